eth_rx_frame_fifo: RTL and testbench

Store-and-forward receive frame FIFO placed directly downstream of the 10G MAC receive AXI-Stream, running in the clk156 domain.
- Buffers each incoming frame in full, then releases it to the packet parser only if the MAC marked it good (tuser=0 on the tlast beat).
- Frames flagged bad, and frames that overflow the buffer, are discarded by rolling back the write pointer.
- The MAC receive interface has no tready, so this block is the first point in the receive path where backpressure exists.

---
 rtl/eth_rx_frame_fifo.sv | 172 +++++++++++++++++
 tb/tb_eth_rx_frame_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO behind the 10G MAC: releases only good frames,
// drops bad/overflowing frames by write-pointer rollback. Ports: s_axis (no tready) in, m_axis out, counters.
module eth_rx_frame_fifo #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64
) (
  input  logic                clk156,
  input  logic                sys_rst,
  input  logic                s_axis_tvalid,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic [31:0]         frame_cnt,
  output logic [31:0]         drop_bad_cnt,
  output logic [31:0]         drop_ovf_cnt
);

  localparam int KW = DATA_W / 8;
  localparam int W  = DATA_W + KW + 1;
  localparam int PW = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     frame_q, frame_d;
  logic [31:0]     bad_q, bad_d;
  logic [31:0]     ovf_q, ovf_d;

  logic [W-1:0]    mem [2**ADDR_W];
  logic [W-1:0]    rdata_q;
  logic            rvalid_q;
  logic [W-1:0]    out_q, out_d;
  logic            ovalid_q, ovalid_d;
  logic [W-1:0]    skid_q, skid_d;
  logic            svalid_q, svalid_d;

  logic            full;
  logic            wr_en;
  logic            rd_en;
  logic            pop;
  logic [1:0]      occ;

  assign full = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    frame_d     = frame_q;
    bad_d       = bad_q;
    ovf_d       = ovf_q;
    wr_en       = 1'b0;
    if (s_axis_tvalid) begin
      unique case (state_q)
        IDLE, WRITE: begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = WRITE;
            if (s_axis_tlast) begin
              state_d = IDLE;
              if (s_axis_tuser) begin
                wr_ptr_d = wr_commit_q;
                bad_d    = bad_q + 1'b1;
              end else begin
                wr_commit_d = wr_ptr_q + 1'b1;
                frame_d     = frame_q + 1'b1;
              end
            end
          end else begin
            // No room: discard the partial frame and swallow the rest.
            wr_ptr_d = wr_commit_q;
            if (s_axis_tlast) begin
              ovf_d   = ovf_q + 1'b1;
              state_d = IDLE;
            end else begin
              state_d = DROP;
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            ovf_d   = ovf_q + 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Prefetch only while out/skid can absorb everything in flight.
  assign pop   = ovalid_q & m_axis_tready;
  assign occ   = 2'(ovalid_q) + 2'(svalid_q) + 2'(rvalid_q);
  assign rd_en = (rd_ptr_q != wr_commit_q) && ((occ - 2'(pop)) < 2'd2);
  assign rd_ptr_d = rd_ptr_q + PW'(rd_en);

  always_comb begin
    out_d    = out_q;
    ovalid_d = ovalid_q;
    skid_d   = skid_q;
    svalid_d = svalid_q;
    if (!ovalid_q || pop) begin
      if (svalid_q) begin
        out_d    = skid_q;
        ovalid_d = 1'b1;
        svalid_d = rvalid_q;
        if (rvalid_q) skid_d = rdata_q;
      end else if (rvalid_q) begin
        out_d    = rdata_q;
        ovalid_d = 1'b1;
      end else begin
        ovalid_d = 1'b0;
      end
    end else if (rvalid_q) begin
      skid_d   = rdata_q;
      svalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk156) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (rd_en) rdata_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      frame_q     <= '0;
      bad_q       <= '0;
      ovf_q       <= '0;
      rvalid_q    <= 1'b0;
      out_q       <= '0;
      ovalid_q    <= 1'b0;
      skid_q      <= '0;
      svalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_q     <= frame_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
      rvalid_q    <= rd_en;
      out_q       <= out_d;
      ovalid_q    <= ovalid_d;
      skid_q      <= skid_d;
      svalid_q    <= svalid_d;
    end
  end

  assign m_axis_tvalid = ovalid_q;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_q;
  assign frame_cnt    = frame_q;
  assign drop_bad_cnt = bad_q;
  assign drop_ovf_cnt = ovf_q;

endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Testbench for eth_rx_frame_fifo (16-entry buffer): directed frame table,
// overflow/drop sequences, random backpressure and async reset.
module tb_eth_rx_frame_fifo;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic [31:0] frame_cnt, drop_bad_cnt, drop_ovf_cnt;

  eth_rx_frame_fifo #(.ADDR_W(4), .DATA_W(64)) dut (
    .clk156(clk), .sys_rst(sys_rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast),
    .frame_cnt(frame_cnt), .drop_bad_cnt(drop_bad_cnt),
    .drop_ovf_cnt(drop_ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    bit bad;
    bit pass;
    int ef;
    int eb;
    int eo;
  } vec_t;

  vec_t        tbl[8];
  logic [72:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          rx_beats = 0;
  int          sent_good = 0;
  int          fid = 0;
  bit          prev_stall = 0;
  logic [72:0] prev_beat;
  bit          done5 = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [72:0] got, e;
    got = {m_tlast, m_tkeep, m_tdata};
    if (sys_rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || got !== prev_beat) begin
          failures++;
          $display("FAIL stable got=%h v=%b exp=%h", got, m_tvalid, prev_beat);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        rx_beats++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat got=%h exp=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL beat got=%h exp=%h", got, e);
          end
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = got;
    end
  end

  task automatic send_beat(logic [63:0] d, logic [7:0] k, logic l, logic u);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(int n, bit bad, bit pass, logic [7:0] lk);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    fid++;
    for (int i = 0; i < n; i++) begin
      d = {16'(fid), 16'(i), 32'($urandom())};
      l = (i == n - 1);
      k = 8'hFF;
      if (l) k = (lk != 8'h00) ? lk : 8'(($urandom_range(1, 255)));
      if (pass) begin
        exp_q.push_back({l, k, d});
        sent_good++;
      end
      send_beat(d, k, l, l & bad);
    end
  endtask

  task automatic drain(string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, k, n, off;

    tbl[0] = '{2,  1'b0, 1'b1, 2, 0, 0};
    tbl[1] = '{4,  1'b1, 1'b0, 2, 1, 0};
    tbl[2] = '{1,  1'b0, 1'b1, 3, 1, 0};
    tbl[3] = '{20, 1'b0, 1'b0, 3, 1, 1};
    tbl[4] = '{2,  1'b0, 1'b1, 4, 1, 1};
    tbl[5] = '{1,  1'b1, 1'b0, 4, 2, 1};
    tbl[6] = '{16, 1'b0, 1'b1, 5, 2, 1};
    tbl[7] = '{17, 1'b0, 1'b0, 5, 2, 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_frame", 64'(frame_cnt), 64'd0);
    chk("rst_ovf", 64'(drop_ovf_cnt), 64'd0);
    sys_rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: 3-beat frame and latency
    send_frame(3, 1'b0, 1'b1, 8'h0F);
    @(negedge clk);
    chk("lat_c0", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_c1", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    chk("lat_c2", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    drain("t1_drain");
    chk("t1_frame", 64'(frame_cnt), 64'd1);

    // Table: good/bad/overflow/exact-fit frames
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].n, tbl[i].bad, tbl[i].pass, 8'h00);
      drain($sformatf("tbl%0d_drain", i));
      chk($sformatf("tbl%0d_frame", i), 64'(frame_cnt), 64'(tbl[i].ef));
      chk($sformatf("tbl%0d_bad", i), 64'(drop_bad_cnt), 64'(tbl[i].eb));
      chk($sformatf("tbl%0d_ovf", i), 64'(drop_ovf_cnt), 64'(tbl[i].eo));
    end

    // Test 3: stalled output, two 7-beat frames fit, third overflows
    m_tready = 1'b0;
    send_frame(7, 1'b0, 1'b1, 8'h00);
    send_frame(7, 1'b0, 1'b1, 8'h00);
    send_frame(5, 1'b0, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_ovf", 64'(drop_ovf_cnt), 64'd3);
    chk("t3_frame", 64'(frame_cnt), 64'd7);
    rx0 = rx_beats;
    m_tready = 1'b1;
    drain("t3_drain");
    chk("t3_beats", 64'(rx_beats - rx0), 64'd14);

    // Test 5: random backpressure, 100 good frames
    off = sent_good - rx_beats;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          n = $urandom_range(1, 9);
          k = 0;
          while ((sent_good - rx_beats - off + n) > 14 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
          end
          if (k >= 1000) begin
            failures++;
            $display("FAIL t5_wait got=timeout exp=space");
          end
          send_frame(n, 1'b0, 1'b1, 8'h00);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done5 = 1;
      end
      begin
        while (!done5) begin
          @(posedge clk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready = 1'b1;
    drain("t5_drain");
    chk("t5_frame", 64'(frame_cnt), 64'd107);

    // Test 6: async reset mid-output and mid-input
    m_tready = 1'b0;
    send_frame(3, 1'b0, 1'b1, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_pre_valid", 64'(m_tvalid), 64'd1);
    send_beat(64'h1111, 8'hFF, 1'b0, 1'b0);
    send_beat(64'h2222, 8'hFF, 1'b0, 1'b0);
    s_tvalid = 1'b1;
    sys_rst  = 1'b1;
    #1;
    chk("t6_valid", 64'(m_tvalid), 64'd0);
    chk("t6_data", m_tdata, 64'd0);
    chk("t6_keep", 64'(m_tkeep), 64'd0);
    chk("t6_last", 64'(m_tlast), 64'd0);
    chk("t6_frame", 64'(frame_cnt), 64'd0);
    chk("t6_bad", 64'(drop_bad_cnt), 64'd0);
    chk("t6_ovf", 64'(drop_ovf_cnt), 64'd0);
    s_tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    sys_rst  = 1'b0;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(2, 1'b0, 1'b1, 8'h00);
    drain("t6_drain");
    chk("t6_frame_after", 64'(frame_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
